uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have the following parameters.
- CLK_HZ, default 50000000, input clock frequency in Hz.
- DATA_BITS, default 8, legal 5..9, data bits per frame.
- OVERSAMPLE, default 16, legal even values 8..16, ticks per bit.
REQ-002 The block SHALL have the following ports, clock and reset first.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  receiver enable; low holds the block idle.
- baud_sel  in  2  rate select: 00=115200, 01=9600, 10=19200, 11=57600.
- parity_mode  in  2  00=none, 01=even, 10=odd, 11=none.
- rx  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  DATA_BITS  received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts the word.
- parity_err  out  1  parity error status of the word in rx_data.
- frame_err  out  1  stop-bit error status of the word in rx_data.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- busy  out  1  FSM is not in IDLE.

Function
REQ-003 rx SHALL pass through a 2-flop synchroniser; all sampling SHALL use the synchronised value rx_s.
REQ-004 The tick divisor SHALL be floor(CLK_HZ/(baud*OVERSAMPLE)), computed at elaboration for all four rates: 27, 325, 162, 54 at the defaults.
REQ-005 The tick counter SHALL emit a one-clk tick on every divisor-th cycle and SHALL restart at start-edge detection.
REQ-006 baud_sel and parity_mode SHALL be latched on start-edge detection; changes mid-frame SHALL affect only the next frame.
REQ-007 The FSM SHALL have five states: IDLE, START, DATA, PARITY, STOP.
REQ-008 IDLE->START SHALL occur on a 1->0 transition of rx_s while en=1.
REQ-009 START SHALL sample rx_s after OVERSAMPLE/2 ticks; a sample of 1 is a false start, returns to IDLE, and produces no output.
REQ-010 DATA SHALL sample DATA_BITS bits, one every OVERSAMPLE ticks, LSB first.
REQ-011 From DATA the FSM SHALL go to PARITY if the latched mode is 01 or 10, otherwise to STOP.
REQ-012 PARITY SHALL sample one bit; parity_err=1 if the XOR of the data bits and the parity bit is 1 for even mode, or 0 for odd mode.
REQ-013 STOP SHALL sample one bit; frame_err=1 if the sample is 0.
REQ-014 rx_data, parity_err and frame_err SHALL update together, with rx_valid rising on the clk after the stop sample; latency from the start edge is (1+DATA_BITS+P+0.5)*OVERSAMPLE ticks plus 3 clk, where P=1 with parity and 0 without.
REQ-015 rx_valid SHALL stay high, with rx_data and the status bits stable, until a clk where rx_valid & rx_ready, then clear on the next clk.
REQ-016 If a frame completes while rx_valid=1 and rx_ready=0, the new word SHALL be discarded, the old word kept, and overrun pulsed for one clk.
REQ-017 If a frame completes in the same clk as a handshake, the new word SHALL be loaded, rx_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-018 After frame_err, the FSM SHALL wait in IDLE until rx_s=1 before accepting another start edge (break handling).
REQ-019 en=0 SHALL synchronously force IDLE and clear rx_valid, parity_err and frame_err, including mid-frame.
REQ-020 busy SHALL be 1 in START, DATA, PARITY and STOP.

Reset
REQ-021 On rst_n=0 the block SHALL asynchronously set FSM=IDLE, all counters=0, synchroniser flops=1, rx_data=0, and rx_valid, parity_err, frame_err, overrun and busy=0.
REQ-022 On reset release the block SHALL be idle; a line held low at release SHALL NOT start a frame until a 1->0 edge is seen.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- en=1, baud_sel=01, parity none, send 0xA5 at 9600 with rx_ready=0 -> rx_data=0xA5, rx_valid=1, both errors 0, valid 3 clk after the stop midpoint.
- parity_mode=01, send 0x37 with parity bit 0 -> parity_err=1; repeat with parity bit 1 -> parity_err=0; odd mode gives the inverse results.
- Stop bit driven 0, line held low for 2 frames, then high, then send 0x5A -> frame_err=1 on the first word, no spurious frames during the break, then 0x5A received clean.
- rx_ready=0 for two back-to-back frames 0x11 and 0x22 -> rx_data stays 0x11 and overrun pulses once; a handshake in the completion clk of 0x22 gives 0x22 with no overrun.
- 3-tick low glitch on rx -> false start, busy returns to 0, rx_valid stays 0.
- en dropped mid-DATA, then rst_n pulsed mid-frame -> IDLE and all outputs at reset values; switching baud_sel to 00 mid-frame completes the frame at 9600, and the next frame is received at 115200.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with runtime baud/parity selection and a
// single-word output buffer (valid/ready handshake, overrun pulse, break handling).
module uart_rx_param #(
    parameter int CLK_HZ     = 50000000,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           baud_sel,
    input  logic [1:0]           parity_mode,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    function automatic int calc_div(input int baud);
        int d;
        d = CLK_HZ / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                          input logic pbit,
                                          input logic [1:0] mode);
        logic x;
        x = (^data) ^ pbit;
        case (mode)
            2'b01:   return x;
            2'b10:   return ~x;
            default: return 1'b0;
        endcase
    endfunction

    localparam int DIV_115200 = calc_div(115200);
    localparam int DIV_9600   = calc_div(9600);
    localparam int DIV_19200  = calc_div(19200);
    localparam int DIV_57600  = calc_div(57600);
    localparam int CNT_W      = $clog2(DIV_9600 + 1);
    localparam int OS_W       = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                 state_r, state_next;
    logic                   sync1_r, rx_s_r, rx_prev_r;
    logic [1:0]             warm_r;
    logic [CNT_W-1:0]       tick_cnt_r, div_m1_s;
    logic [OS_W-1:0]        os_cnt_r;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r, rx_data_r;
    logic                   pbit_r;
    logic [1:0]             baud_r, pmode_r;
    logic                   rx_valid_r, parity_err_r, frame_err_r, overrun_r, busy_r;
    logic                   tick_s, os_wrap_s, sample_s, start_edge_s, has_parity_s, frame_done_s;

    // warm_r keeps the reset-value 1s of the synchroniser from faking a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= 1'b1;
            rx_s_r    <= 1'b1;
            warm_r    <= 2'b00;
            rx_prev_r <= 1'b0;
        end else begin
            sync1_r   <= rx;
            rx_s_r    <= sync1_r;
            warm_r    <= {warm_r[0], 1'b1};
            rx_prev_r <= rx_s_r & warm_r[1];
        end
    end

    // Tick divisor for the rate latched at the start of the current frame
    always_comb begin
        case (baud_r)
            2'b00:   div_m1_s = CNT_W'(DIV_115200 - 1);
            2'b01:   div_m1_s = CNT_W'(DIV_9600 - 1);
            2'b10:   div_m1_s = CNT_W'(DIV_19200 - 1);
            2'b11:   div_m1_s = CNT_W'(DIV_57600 - 1);
            default: div_m1_s = CNT_W'(DIV_115200 - 1);
        endcase
    end

    assign tick_s       = (tick_cnt_r == div_m1_s);
    assign os_wrap_s    = (state_r == ST_START) ? (os_cnt_r == OS_W'(OVERSAMPLE/2 - 1))
                                                : (os_cnt_r == OS_W'(OVERSAMPLE - 1));
    assign sample_s     = tick_s & os_wrap_s;
    assign start_edge_s = en & rx_prev_r & ~rx_s_r;
    assign has_parity_s = (pmode_r == 2'b01) || (pmode_r == 2'b10);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // FSM next-state logic; frame_done_s marks the stop-bit sample
    always_comb begin
        state_next   = state_r;
        frame_done_s = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s) state_next = ST_START;
                    else              state_next = ST_IDLE;
                end
                ST_START: begin
                    if (sample_s) state_next = rx_s_r ? ST_IDLE : ST_DATA;
                    else          state_next = ST_START;
                end
                ST_DATA: begin
                    if (sample_s && (bit_cnt_r == BIT_W'(DATA_BITS - 1)))
                        state_next = has_parity_s ? ST_PARITY : ST_STOP;
                    else
                        state_next = ST_DATA;
                end
                ST_PARITY: begin
                    if (sample_s) state_next = ST_STOP;
                    else          state_next = ST_PARITY;
                end
                ST_STOP: begin
                    if (sample_s) begin
                        state_next   = ST_IDLE;
                        frame_done_s = 1'b1;
                    end else begin
                        state_next   = ST_STOP;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Tick, oversample and bit counters; all held at zero outside a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= '0;
            os_cnt_r   <= '0;
            bit_cnt_r  <= '0;
        end else if (state_r == ST_IDLE || state_next == ST_IDLE) begin
            tick_cnt_r <= '0;
            os_cnt_r   <= '0;
            bit_cnt_r  <= '0;
        end else begin
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + CNT_W'(1);
            if (sample_s)    os_cnt_r <= '0;
            else if (tick_s) os_cnt_r <= os_cnt_r + OS_W'(1);
            else             os_cnt_r <= os_cnt_r;
            if (sample_s && state_r == ST_DATA) bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            else                                bit_cnt_r <= bit_cnt_r;
        end
    end

    // Frame settings latch at the start edge; data shifts in LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_r  <= 2'b00;
            pmode_r <= 2'b00;
            shift_r <= '0;
            pbit_r  <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && state_next == ST_START) begin
                baud_r  <= baud_sel;
                pmode_r <= parity_mode;
            end
            if (sample_s && state_r == ST_DATA)   shift_r <= {rx_s_r, shift_r[DATA_BITS-1:1]};
            if (sample_s && state_r == ST_PARITY) pbit_r  <= rx_s_r;
        end
    end

    // Output buffer: a completed frame is dropped only if the old word is not being taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= (state_next != ST_IDLE);
            if (!en) begin
                rx_valid_r   <= 1'b0;
                parity_err_r <= 1'b0;
                frame_err_r  <= 1'b0;
                overrun_r    <= 1'b0;
            end else begin
                overrun_r <= 1'b0;
                if (frame_done_s) begin
                    if (!rx_valid_r || rx_ready) begin
                        rx_data_r    <= shift_r;
                        parity_err_r <= parity_error(shift_r, pbit_r, pmode_r);
                        frame_err_r  <= ~rx_s_r;
                        rx_valid_r   <= 1'b1;
                    end else begin
                        overrun_r    <= 1'b1;
                    end
                end else if (rx_valid_r && rx_ready) begin
                    rx_valid_r <= 1'b0;
                end
            end
        end
    end

    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;
endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: table of frames plus directed corner cases,
// with a scoreboard of expected words popped at each handshake.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int CLK_HZ = 3686400;
    localparam int DB     = 8;
    localparam int OS     = 16;

    logic          clk = 1'b0;
    logic          rst_n, en, rx, rx_ready;
    logic [1:0]    baud_sel, parity_mode;
    logic [DB-1:0] rx_data;
    logic          rx_valid, parity_err, frame_err, overrun, busy;

    // 3686400 / (baud*16): 115200 -> 2, 9600 -> 24, 19200 -> 12, 57600 -> 4
    int div_tab [4] = '{2, 24, 12, 4};

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pm;
        logic       pbit;
        logic       stop;
        logic [1:0] baud;
        logic       perr;
        logic       ferr;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs [10];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ovr_cnt = 0;
    int   ov0;

    uart_rx_param #(.CLK_HZ(CLK_HZ), .DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .baud_sel(baud_sel),
        .parity_mode(parity_mode), .rx(rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [1:0] pm, input logic pbit,
                              input logic stop_v, input int bit_clks, input logic tail,
                              input int tail_bits);
        rx = 1'b0;
        repeat (bit_clks) tick();
        for (int i = 0; i < DB; i++) begin
            rx = data[i];
            repeat (bit_clks) tick();
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            rx = pbit;
            repeat (bit_clks) tick();
        end
        rx = stop_v;
        repeat (bit_clks) tick();
        rx = tail;
        repeat (tail_bits * bit_clks) tick();
    endtask

    // Sends a frame and measures clocks from the start-bit drive to rx_valid rising
    task automatic run_frame(input string name, input logic [7:0] data, input logic [1:0] pm,
                             input logic pbit, input logic stop_v, input logic [1:0] baud,
                             input logic tail, input int tail_bits);
        int exp_lat;
        int lat;
        exp_lat = (((pm == 2'b01) || (pm == 2'b10)) ? 168 : 152) * div_tab[baud] + 3;
        lat = -1;
        fork
            send_frame(data, pm, pbit, stop_v, OS * div_tab[baud], tail, tail_bits);
            begin
                for (int k = 1; k <= 2 * exp_lat && lat < 0; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (rx_valid) lat = k;
                end
            end
        join
        check({name, " latency"}, lat, exp_lat);
    endtask

    // Scoreboard: every handshake must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", rx_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("word data", {24'd0, rx_data}, {24'd0, mon_e.data});
                check("word parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
                check("word frame_err", {31'd0, frame_err}, {31'd0, mon_e.ferr});
            end
        end
        if (overrun) ovr_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; rx = 1'b1; rx_ready = 1'b0;
        baud_sel = 2'b00; parity_mode = 2'b00;
        // data, pm, pbit, stop, baud, perr, ferr
        vecs[0] = '{8'h37, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0};
        vecs[1] = '{8'h37, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[2] = '{8'h37, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[3] = '{8'h37, 2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
        vecs[4] = '{8'hA5, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 2'b11, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[7] = '{8'h81, 2'b10, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0};
        vecs[8] = '{8'h3C, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
        vecs[9] = '{8'h6E, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};

        repeat (3) tick();
        @(negedge clk);
        check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rx_data", {24'd0, rx_data}, 32'd0);
        check("reset errors", {30'd0, parity_err, frame_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        en = 1'b1;
        repeat (4) tick();

        // 0xA5 at 9600, held unconsumed
        baud_sel = 2'b01; parity_mode = 2'b00; rx_ready = 1'b0;
        sb_q.push_back('{8'hA5, 1'b0, 1'b0});
        run_frame("a5_9600", 8'hA5, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1);
        @(negedge clk);
        check("a5 held valid", {31'd0, rx_valid}, 32'd1);
        check("a5 held data", {24'd0, rx_data}, 32'h0000_00A5);
        check("a5 held errors", {30'd0, parity_err, frame_err}, 32'd0);
        tick();
        rx_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("a5 consumed", {31'd0, rx_valid}, 32'd0);
        tick();

        // Table of frames with ready held high
        foreach (vecs[i]) begin
            baud_sel    = vecs[i].baud;
            parity_mode = vecs[i].pm;
            sb_q.push_back('{vecs[i].data, vecs[i].perr, vecs[i].ferr});
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].pm, vecs[i].pbit,
                      vecs[i].stop, vecs[i].baud, 1'b1, 1);
        end

        // Overrun: second frame dropped, then handshake in the completion clk
        rx_ready = 1'b0; baud_sel = 2'b00; parity_mode = 2'b00;
        ov0 = ovr_cnt;
        sb_q.push_back('{8'h11, 1'b0, 1'b0});
        run_frame("ovr_11", 8'h11, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b1, 32, 1'b1, 1);
        @(negedge clk);
        check("ovr old data kept", {24'd0, rx_data}, 32'h0000_0011);
        check("ovr valid kept", {31'd0, rx_valid}, 32'd1);
        check("ovr pulse count", ovr_cnt - ov0, 32'd1);
        tick();
        sb_q.push_back('{8'h22, 1'b0, 1'b0});
        fork
            send_frame(8'h22, 2'b00, 1'b0, 1'b1, 32, 1'b1, 1);
            begin
                repeat (2 + 152 * 2) tick();
                rx_ready = 1'b1;
            end
        join
        check("handshake no overrun", ovr_cnt - ov0, 32'd1);

        // Break: stop bit 0 then line low for two frames
        sb_q.push_back('{8'hC3, 1'b0, 1'b1});
        run_frame("break_c3", 8'hC3, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 20);
        @(negedge clk);
        check("break idle", {31'd0, busy}, 32'd0);
        check("break no spurious", sb_q.size(), 32'd0);
        tick();
        rx = 1'b1;
        repeat (64) tick();
        sb_q.push_back('{8'h5A, 1'b0, 1'b0});
        run_frame("after_break", 8'h5A, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1);

        // 3-clk glitch: false start
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("glitch busy", {31'd0, busy}, 32'd1);
        repeat (40) tick();
        @(negedge clk);
        check("glitch back idle", {31'd0, busy}, 32'd0);
        check("glitch no valid", {31'd0, rx_valid}, 32'd0);
        tick();

        // en dropped mid-DATA clears pending word and status
        rx_ready = 1'b0;
        send_frame(8'h96, 2'b00, 1'b0, 1'b0, 32, 1'b1, 1);
        @(negedge clk);
        check("pre-en valid", {31'd0, rx_valid}, 32'd1);
        check("pre-en frame_err", {31'd0, frame_err}, 32'd1);
        tick();
        rx = 1'b0;
        repeat (96) tick();
        @(negedge clk);
        check("en mid busy", {31'd0, busy}, 32'd1);
        tick();
        en = 1'b0;
        tick();
        @(negedge clk);
        check("en off busy", {31'd0, busy}, 32'd0);
        check("en off valid", {31'd0, rx_valid}, 32'd0);
        check("en off errors", {30'd0, parity_err, frame_err}, 32'd0);
        tick();
        rx = 1'b1;
        repeat (5) tick();
        en = 1'b1;
        repeat (20) tick();

        // Reset mid-frame, line still low at release
        rx = 1'b0;
        repeat (100) tick();
        @(negedge clk);
        check("rst mid busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst async busy", {31'd0, busy}, 32'd0);
        check("rst async data", {24'd0, rx_data}, 32'd0);
        check("rst async flags", {28'd0, rx_valid, parity_err, frame_err, overrun}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        @(negedge clk);
        check("low at release no start", {31'd0, busy}, 32'd0);
        tick();
        rx = 1'b1;
        repeat (10) tick();

        // Baud change mid-frame only affects the next frame
        rx_ready = 1'b1; baud_sel = 2'b01; parity_mode = 2'b00;
        sb_q.push_back('{8'hC6, 1'b0, 1'b0});
        fork
            run_frame("switch_9600", 8'hC6, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1);
            begin
                repeat (1000) tick();
                baud_sel = 2'b00;
            end
        join
        sb_q.push_back('{8'h39, 1'b0, 1'b0});
        run_frame("next_115200", 8'h39, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1);

        repeat (20) tick();
        check("scoreboard drained", sb_q.size(), 32'd0);
        check("overrun total", ovr_cnt, 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
